// File: rtl/mem_arbiter.sv
// Shared main-memory port arbiter between the I-cache and D-cache miss paths.
// Define ARB_RR_EN for round-robin tie-breaking; the default gives D fixed priority over I.
module mem_arbiter #(
  parameter int AW      = 16,
  parameter int DW      = 16,
  parameter int MEM_LAT = 4
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          i_req,
  input  logic [AW-1:0] i_addr,
  output logic          i_done,
  input  logic          d_req,
  input  logic          d_wr,
  input  logic [AW-1:0] d_addr,
  input  logic [DW-1:0] d_wdata,
  output logic          d_done,
  output logic [DW-1:0] rdata,
  output logic          err,
  output logic          mem_rd,
  output logic          mem_wr,
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_wdata,
  input  logic          mem_stall,
  input  logic [DW-1:0] mem_rdata,
  output logic          busy,
  output logic          owner
);

  // state  | meaning
  // IDLE   | no access in flight, arbitrate pending requests
  // ISSUE  | strobe driven, held while memory stalls
  // WAIT   | counting down the fixed read latency
  // DONE   | one-cycle done pulse to the winner, err if misaligned
  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT, S_DONE} state_t;

  localparam logic [3:0] LAT_M1 = 4'(MEM_LAT - 1);

  state_t        state_q, state_d;
  logic          owner_q, owner_d;
  logic          wr_q, wr_d;
  logic          err_q, err_d;
  logic [AW-1:0] addr_q, addr_d;
  logic [DW-1:0] wdata_q, wdata_d;
  logic [DW-1:0] rdata_q, rdata_d;
  logic [3:0]    cnt_q, cnt_d;

  logic          pick_d;
  logic [AW-1:0] win_addr;

  // On a tie, round-robin hands the grant to the side that did not win last.
  always_comb begin
`ifdef ARB_RR_EN
    pick_d = d_req & (~i_req | ~owner_q);
`else
    pick_d = d_req;
`endif
    win_addr = pick_d ? d_addr : i_addr;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      owner_q <= 1'b1;
      wr_q    <= 1'b0;
      err_q   <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      owner_q <= owner_d;
      wr_q    <= wr_d;
      err_q   <= err_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      rdata_q <= rdata_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    owner_d = owner_q;
    wr_d    = wr_q;
    err_d   = err_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    rdata_d = rdata_q;
    cnt_d   = cnt_q;
    case (state_q)
      S_IDLE: begin
        if (i_req || d_req) begin
          owner_d = pick_d;
          addr_d  = win_addr;
          wr_d    = pick_d & d_wr;
          if (pick_d) wdata_d = d_wdata;
          err_d   = win_addr[0];
          state_d = win_addr[0] ? S_DONE : S_ISSUE;
        end
      end
      S_ISSUE: begin
        if (!mem_stall) begin
          cnt_d   = LAT_M1;
          state_d = S_WAIT;
        end
      end
      S_WAIT: begin
        if (cnt_q == 4'd0) begin
          if (!wr_q) rdata_d = mem_rdata;
          state_d = S_DONE;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      S_DONE: begin
        err_d   = 1'b0;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    mem_rd    = (state_q == S_ISSUE) & ~wr_q;
    mem_wr    = (state_q == S_ISSUE) &  wr_q;
    i_done    = (state_q == S_DONE) & ~owner_q;
    d_done    = (state_q == S_DONE) &  owner_q;
    err       = (state_q == S_DONE) &  err_q;
    busy      = (state_q != S_IDLE);
    mem_addr  = addr_q;
    mem_wdata = wdata_q;
    rdata     = rdata_q;
    owner     = owner_q;
  end

endmodule
